cam_param_age: RTL and testbench
================================

// Module: cam_param_age
// PURPOSE
//  Parametrised successor of the 48x64 MAC CAM: key/data learning table with per-entry age
//  counters, duplicate-free write, refresh, whole-table aging and init sweep. Sits in the
//  switch forwarding path: ingress learns {MAC,port}; egress lookup searches MAC, gets port.
// PARAMETERS
//  KW       48  key width (MAC)
//  DW       4   data/payload width (port id)
//  DEPTH    64  entries, power of two >=2
//  AW       $clog2(DEPTH)  derived, not overridden
//  AGE_MAX  3   aging passes an unrefreshed entry survives
// PORTS
//  clk          in  1      clock
//  rstn         in  1      asynchronous active-low reset
//  init_req     in  1      level req: clear whole table
//  init_ack     out 1      1-cycle pulse, init done
//  srch_req     in  1      1-cycle search strobe
//  srch_key     in  KW     search key, sampled with srch_req
//  srch_hit     out 1      pulse, key found
//  srch_miss    out 1      pulse, key absent
//  srch_addr    out AW     matched index (valid with srch_hit)
//  srch_data    out DW     matched payload (valid with srch_hit)
//  wr_req       in  1      level req: learn {wr_key,wr_data}
//  wr_key       in  KW     key, held stable with wr_req
//  wr_data      in  DW     payload, held stable with wr_req
//  wr_ack       out 1      1-cycle pulse, write done
//  wr_addr      out AW     index written (valid with wr_ack)
//  wr_fail      out 1      with wr_ack: table full, nothing written
//  refresh_req  in  1      level req: reset age of entry refresh_addr
//  refresh_addr in  AW     entry index
//  refresh_ack  out 1      1-cycle pulse
//  aging_req    in  1      level req: one aging pass
//  aging_ack    out 1      1-cycle pulse
//  empty        out 1      no valid entries
//  full         out 1      all entries valid
//  count        out AW+1   number of valid entries
// BEHAVIOUR
//  Reset: all valid bits 0, every ack/hit/miss/fail 0, addr/data 0, count 0, empty 1, full 0, FSM IDLE.
//  Handshake: req held high until ack; ack is one-cycle; FSM enters ACK state for one cycle
//   after each ack and ignores all reqs there, so a req dropped after ack is never re-served.
//  Priority of pending reqs in IDLE: init > aging > refresh > write.
//  FSM: IDLE, INIT (clear entry i per cycle, i=0..DEPTH-1, init_ack on last, DEPTH cycles),
//   WR_LOOK (compare wr_key all entries), WR_DO (update/alloc, wr_ack), AGE (one cycle, ack),
//   REF (one cycle, ack), ACK.
//  Write: latency 2 cycles IDLE->ack. Key present: overwrite data, age=0, wr_addr=match index,
//   count unchanged. Absent: lowest-index free entry, valid=1, age=0. Absent and full: wr_fail=1, no change.
//  Search: independent of FSM, fixed 1-cycle latency, exactly one of hit/miss per strobe;
//   sees table state before any same-cycle update; during INIT always miss. Multiple matches
//   impossible by construction; encoder still picks lowest index.
//  Aging pass (all entries parallel): valid & age==AGE_MAX -> valid=0; valid -> age+1.
//   Entry removed on the (AGE_MAX+1)th pass since last write/refresh.
//  Refresh: valid entry -> age=0; invalid entry -> ack, no change.
//  Age counters $clog2(AGE_MAX+1) bits, never wrap. count/empty/full registered, updated the
//   cycle after any valid-bit change.
//  Reset mid-operation: immediate return to reset state; no ack issued for interrupted req.
// STRUCTURE
//  cam_pkg: FSM state enum, localparam AGEW=$clog2(AGE_MAX+1), ack-pulse helper function.
//  Sub-module cam_prio_enc #(DEPTH): DEPTH-bit vector -> {found, lowest set index}; two instances
//   (key match vector, free vector ~valid).
//  Top: storage regs, match compare, FSM, popcount via increment/decrement of count.
// TESTING
//  1 Reset: all outputs at reset values, empty=1, count=0; search 0x10 -> srch_miss.
//  2 init, then write keys 1..64 data=key[3:0] -> wr_addr 0..63, full=1, count=64;
//    65th write key 0x41 -> wr_ack, wr_fail=1, count 64.
//  3 search 0x10 -> hit, addr 15, data 0x0 one cycle later; search 0xf0f1f2f3f4f5 -> miss.
//  4 write existing key 0x20 data 0x7 -> wr_addr 31, wr_fail=0, count 64; search 0x20 -> data 0x7.
//  5 AGE_MAX=3: 3 aging passes -> count 64; refresh addr 16 and 1; 4th pass -> count 2,
//    only keys 0x11,0x02 hit; refresh of invalid addr 5 -> refresh_ack, count 2.
//  6 init_req and aging_req together -> init_ack first, aging_ack after; rstn low during INIT
//    -> no init_ack, outputs at reset values, empty=1.

Source files
------------

// File: rtl/cam_param_age_pkg.sv
// Shared types and helpers for the parametrised MAC learning CAM.
package cam_param_age_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WR_LOOK, S_WR_DO, S_AGE, S_REF, S_ACK
  } cam_state_t;

  // Every ack is a one-cycle pulse tied to being in the serving state.
  function automatic logic ack_pulse(cam_state_t st, cam_state_t ack_st);
    return st == ack_st;
  endfunction

  // Age counter width; at least one bit even for AGE_MAX=0.
  function automatic int age_w(int age_max);
    return (age_max < 1) ? 1 : $clog2(age_max + 1);
  endfunction

endpackage

// File: rtl/cam_param_age_if.sv
// Request/ack bus of the learning CAM: search, learn, refresh, aging, init, occupancy.
interface cam_param_age_if #(
  parameter int KW = 48,
  parameter int DW = 4,
  parameter int AW = 6
);
  logic          init_req, init_ack;
  logic          srch_req, srch_hit, srch_miss;
  logic [KW-1:0] srch_key;
  logic [AW-1:0] srch_addr;
  logic [DW-1:0] srch_data;
  logic          wr_req, wr_ack, wr_fail;
  logic [KW-1:0] wr_key;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic          refresh_req, refresh_ack;
  logic [AW-1:0] refresh_addr;
  logic          aging_req, aging_ack;
  logic          empty, full;
  logic [AW:0]   count;

  modport master (
    output init_req, srch_req, srch_key, wr_req, wr_key, wr_data,
           refresh_req, refresh_addr, aging_req,
    input  init_ack, srch_hit, srch_miss, srch_addr, srch_data,
           wr_ack, wr_addr, wr_fail, refresh_ack, aging_ack, empty, full, count
  );
  modport slave (
    input  init_req, srch_req, srch_key, wr_req, wr_key, wr_data,
           refresh_req, refresh_addr, aging_req,
    output init_ack, srch_hit, srch_miss, srch_addr, srch_data,
           wr_ack, wr_addr, wr_fail, refresh_ack, aging_ack, empty, full, count
  );
endinterface

// File: rtl/cam_param_age_prio_enc.sv
// Lowest-index priority encoder: DEPTH-bit vector -> {found, index}.
module cam_prio_enc #(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] vec,
  output logic             found,
  output logic [AW-1:0]    idx
);
  always_comb begin
    found = |vec;
    idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (vec[i]) idx = AW'(i);
  end
endmodule

// File: rtl/cam_param_age.sv
// Key/data learning CAM with per-entry age counters, duplicate-free learn,
// refresh, whole-table aging pass and an entry-per-cycle init sweep.
module cam_param_age
  import cam_param_age_pkg::*;
#(
  parameter int KW      = 48,
  parameter int DW      = 4,
  parameter int DEPTH   = 64,
  parameter int AGE_MAX = 3
) (
  input  logic clk,
  input  logic rstn,
  cam_param_age_if.slave bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int AGEW = age_w(AGE_MAX);

  cam_state_t state, state_nxt;

  logic [DEPTH-1:0]           valid;
  logic [DEPTH-1:0][KW-1:0]   keys;
  logic [DEPTH-1:0][DW-1:0]   datas;
  logic [DEPTH-1:0][AGEW-1:0] ages;

  logic [DEPTH-1:0] srch_vec, wr_vec;
  logic             srch_found, wr_found, free_found;
  logic [AW-1:0]    srch_idx, wr_idx, free_idx;

  logic [AW-1:0] init_idx, wl_idx;
  logic          wl_upd, wl_new;
  logic          hit_q, miss_q;
  logic [AW-1:0] saddr_q;
  logic [DW-1:0] sdata_q;
  logic [AW:0]   popcnt, count_q;
  logic          empty_q, full_q;
  logic          srch_ok;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      srch_vec[i] = valid[i] && (keys[i] == bus.srch_key);
      wr_vec[i]   = valid[i] && (keys[i] == bus.wr_key);
    end
  end

  cam_prio_enc #(.DEPTH(DEPTH)) u_srch_enc (.vec(srch_vec), .found(srch_found), .idx(srch_idx));
  cam_prio_enc #(.DEPTH(DEPTH)) u_wr_enc   (.vec(wr_vec),   .found(wr_found),   .idx(wr_idx));
  cam_prio_enc #(.DEPTH(DEPTH)) u_free_enc (.vec(~valid),   .found(free_found), .idx(free_idx));

  // Search path runs regardless of the FSM; the table is half-cleared during INIT, so it misses.
  assign srch_ok = srch_found && (state != S_INIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      saddr_q <= '0;
      sdata_q <= '0;
    end else begin
      hit_q  <= bus.srch_req && srch_ok;
      miss_q <= bus.srch_req && !srch_ok;
      if (bus.srch_req && srch_ok) begin
        saddr_q <= srch_idx;
        sdata_q <= datas[srch_idx];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if      (bus.init_req)    state_nxt = S_INIT;
        else if (bus.aging_req)   state_nxt = S_AGE;
        else if (bus.refresh_req) state_nxt = S_REF;
        else if (bus.wr_req)      state_nxt = S_WR_LOOK;
      end
      S_INIT:                   if (init_idx == AW'(DEPTH - 1)) state_nxt = S_ACK;
      S_WR_LOOK:                state_nxt = S_WR_DO;
      S_WR_DO, S_AGE, S_REF:    state_nxt = S_ACK;
      S_ACK:                    state_nxt = S_IDLE;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      init_idx <= '0;
      wl_idx   <= '0;
      wl_upd   <= 1'b0;
      wl_new   <= 1'b0;
      valid    <= '0;
      keys     <= '0;
      datas    <= '0;
      ages     <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        S_IDLE: init_idx <= '0;
        S_INIT: begin
          valid[init_idx] <= 1'b0;
          init_idx        <= init_idx + 1'b1;
        end
        S_WR_LOOK: begin
          wl_upd <= wr_found;
          wl_new <= free_found;
          wl_idx <= wr_found ? wr_idx : free_idx;
        end
        S_WR_DO: begin
          if (wl_upd || wl_new) begin
            valid[wl_idx] <= 1'b1;
            keys[wl_idx]  <= bus.wr_key;
            datas[wl_idx] <= bus.wr_data;
            ages[wl_idx]  <= '0;
          end
        end
        S_AGE: begin
          for (int i = 0; i < DEPTH; i++)
            if (valid[i]) begin
              if (ages[i] == AGEW'(AGE_MAX)) valid[i] <= 1'b0;
              else                           ages[i]  <= ages[i] + 1'b1;
            end
        end
        S_REF: if (valid[bus.refresh_addr]) ages[bus.refresh_addr] <= '0;
        default: ;
      endcase
    end
  end

  // Occupancy lags the valid vector by one cycle.
  always_comb begin
    popcnt = '0;
    for (int i = 0; i < DEPTH; i++) popcnt = popcnt + {{AW{1'b0}}, valid[i]};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      count_q <= popcnt;
      empty_q <= (popcnt == '0);
      full_q  <= (popcnt == (AW+1)'(DEPTH));
    end
  end

  assign bus.init_ack    = ack_pulse(state, S_INIT) && (init_idx == AW'(DEPTH - 1));
  assign bus.wr_ack      = ack_pulse(state, S_WR_DO);
  assign bus.wr_fail     = ack_pulse(state, S_WR_DO) && !wl_upd && !wl_new;
  assign bus.wr_addr     = wl_idx;
  assign bus.aging_ack   = ack_pulse(state, S_AGE);
  assign bus.refresh_ack = ack_pulse(state, S_REF);
  assign bus.srch_hit    = hit_q;
  assign bus.srch_miss   = miss_q;
  assign bus.srch_addr   = saddr_q;
  assign bus.srch_data   = sdata_q;
  assign bus.count       = count_q;
  assign bus.empty       = empty_q;
  assign bus.full        = full_q;

endmodule

// File: tb/tb_cam_param_age.sv
// Randomised self-checking bench for cam_param_age against an array-based table model.
`timescale 1ns/1ps
module tb_cam_param_age;
  localparam int KW = 48, DW = 4, DEPTH = 64, AW = 6, AGE_MAX = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cam_param_age_if #(.KW(KW), .DW(DW), .AW(AW)) b();
  cam_param_age #(.KW(KW), .DW(DW), .DEPTH(DEPTH), .AGE_MAX(AGE_MAX)) dut (
    .clk(clk), .rstn(rstn), .bus(b)
  );

  int checks = 0;
  int errors = 0;

  logic          mvalid [DEPTH];
  logic [KW-1:0] mkey   [DEPTH];
  logic [DW-1:0] mdata  [DEPTH];
  int            mage   [DEPTH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mvalid[i]) n++;
    return n;
  endfunction

  function automatic int m_find(input logic [KW-1:0] k);
    for (int i = 0; i < DEPTH; i++) if (mvalid[i] && mkey[i] == k) return i;
    return -1;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < DEPTH; i++) if (!mvalid[i]) return i;
    return -1;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < DEPTH; i++) begin mvalid[i] = 1'b0; mage[i] = 0; end
  endfunction

  function automatic logic sel_ack(input int which);
    case (which)
      0: return b.init_ack;
      1: return b.wr_ack;
      2: return b.refresh_ack;
      default: return b.aging_ack;
    endcase
  endfunction

  // Waits (bounded) for the selected ack; lat = negedges since the request was raised.
  task automatic wait_ack(input int which, input int start, output bit got, output int lat);
    got = 0; lat = 0;
    for (int c = start; c <= 200; c++) begin
      @(negedge clk);
      if (sel_ack(which)) begin got = 1; lat = c; break; end
    end
  endtask

  task automatic chk_occ(input string tag);
    chk({tag, ".count"}, 64'(b.count), 64'(m_count()));
    chk({tag, ".empty"}, 64'(b.empty), 64'(m_count() == 0));
    chk({tag, ".full"},  64'(b.full),  64'(m_count() == DEPTH));
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ".acks"}, {b.init_ack, b.wr_ack, b.wr_fail, b.refresh_ack, b.aging_ack}, 0);
    chk({tag, ".srch"}, {b.srch_hit, b.srch_miss, b.srch_addr, b.srch_data}, 0);
    chk({tag, ".waddr"}, 64'(b.wr_addr), 0);
    chk({tag, ".occ"}, {b.count, b.empty, b.full}, {7'd0, 1'b1, 1'b0});
  endtask

  task automatic op_write(input logic [KW-1:0] k, input logic [DW-1:0] d);
    int hit_i, free_i, lat; bit got;
    hit_i = m_find(k); free_i = m_free();
    b.wr_key = k; b.wr_data = d; b.wr_req = 1'b1;
    wait_ack(1, 1, got, lat);
    chk("wr.ack", 64'(got), 1);
    chk("wr.lat", 64'(lat), 2);
    if (hit_i >= 0) begin
      chk("wr.addr_upd", 64'(b.wr_addr), 64'(hit_i));
      chk("wr.fail_upd", 64'(b.wr_fail), 0);
      mdata[hit_i] = d; mage[hit_i] = 0;
    end else if (free_i >= 0) begin
      chk("wr.addr_new", 64'(b.wr_addr), 64'(free_i));
      chk("wr.fail_new", 64'(b.wr_fail), 0);
      mvalid[free_i] = 1'b1; mkey[free_i] = k; mdata[free_i] = d; mage[free_i] = 0;
    end else begin
      chk("wr.fail_full", 64'(b.wr_fail), 1);
    end
    b.wr_req = 1'b0;
    repeat (2) @(negedge clk);
    chk_occ("wr");
  endtask

  task automatic op_search(input logic [KW-1:0] k);
    int i;
    i = m_find(k);
    b.srch_key = k; b.srch_req = 1'b1;
    @(negedge clk);
    b.srch_req = 1'b0;
    chk("srch.hit",  64'(b.srch_hit),  64'(i >= 0));
    chk("srch.miss", 64'(b.srch_miss), 64'(i < 0));
    if (i >= 0) begin
      chk("srch.addr", 64'(b.srch_addr), 64'(i));
      chk("srch.data", 64'(b.srch_data), 64'(mdata[i]));
    end
  endtask

  task automatic op_age();
    int lat; bit got;
    b.aging_req = 1'b1;
    wait_ack(3, 1, got, lat);
    chk("age.ack", 64'(got), 1);
    b.aging_req = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (mvalid[i]) begin
        if (mage[i] == AGE_MAX) mvalid[i] = 1'b0;
        else                    mage[i]++;
      end
    repeat (2) @(negedge clk);
    chk_occ("age");
  endtask

  task automatic op_ref(input int a);
    int lat; bit got;
    b.refresh_addr = AW'(a); b.refresh_req = 1'b1;
    wait_ack(2, 1, got, lat);
    chk("ref.ack", 64'(got), 1);
    b.refresh_req = 1'b0;
    if (mvalid[a]) mage[a] = 0;
    repeat (2) @(negedge clk);
    chk_occ("ref");
  endtask

  // Also probes a still-present key mid-sweep: must miss.
  task automatic op_init();
    int lat, probe; bit got;
    probe = -1;
    for (int i = 0; i < DEPTH; i++) if (mvalid[i]) probe = i;
    b.init_req = 1'b1;
    @(negedge clk);
    b.srch_key = (probe >= 0) ? mkey[probe] : KW'($urandom);
    b.srch_req = 1'b1;
    @(negedge clk);
    b.srch_req = 1'b0;
    chk("init.srch_miss", {b.srch_hit, b.srch_miss}, 2'b01);
    wait_ack(0, 3, got, lat);
    chk("init.ack", 64'(got), 1);
    chk("init.lat", 64'(lat), DEPTH);
    b.init_req = 1'b0;
    m_clear();
    repeat (2) @(negedge clk);
    chk_occ("init");
  endtask

  initial begin
    logic [KW-1:0] k;
    int lat, r; bit got;
    b.init_req = 0; b.srch_req = 0; b.srch_key = '0; b.wr_req = 0; b.wr_key = '0;
    b.wr_data = '0; b.refresh_req = 0; b.refresh_addr = '0; b.aging_req = 0;
    m_clear();

    // Reset state
    repeat (2) @(negedge clk);
    chk_rst("rst");
    rstn = 1'b1;
    @(negedge clk);
    op_search(48'h10);

    // Fill table, then overflow
    op_init();
    for (int n = 1; n <= DEPTH; n++) begin
      k = KW'(n);
      op_write(k, k[DW-1:0]);
    end
    chk("fill.full", {b.full, b.count}, {1'b1, 7'd64});
    op_write(48'h41, 4'h9);
    chk("ovf.count", 64'(b.count), 64);

    // Search hit/miss, pulse width
    op_search(48'h10);
    chk("t3.addr", {b.srch_addr, b.srch_data}, {6'd15, 4'h0});
    @(negedge clk);
    chk("t3.pulse", {b.srch_hit, b.srch_miss}, 2'b00);
    op_search(48'hf0f1f2f3f4f5);

    // Overwrite of existing key
    op_write(48'h20, 4'h7);
    chk("t4.addr", 64'(b.wr_addr), 31);
    op_search(48'h20);
    chk("t4.data", 64'(b.srch_data), 7);

    // Aging and refresh
    repeat (AGE_MAX) op_age();
    chk("t5.count3", 64'(b.count), 64);
    op_ref(16);
    op_ref(1);
    op_age();
    chk("t5.count4", 64'(b.count), 2);
    op_search(48'h11);
    op_search(48'h02);
    op_search(48'h10);
    op_ref(5);

    // init beats aging when both pending
    b.init_req = 1'b1; b.aging_req = 1'b1;
    got = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (b.init_ack || b.aging_ack) begin got = 1; break; end
    end
    chk("pri.first", {got, b.init_ack, b.aging_ack}, 3'b110);
    b.init_req = 1'b0;
    m_clear();
    wait_ack(3, 1, got, lat);
    chk("pri.age_ack", 64'(got), 1);
    b.aging_req = 1'b0;
    repeat (2) @(negedge clk);
    chk_occ("pri");

    // Reset in the middle of INIT
    op_write(48'h77, 4'h3);
    op_write(48'h78, 4'h4);
    b.init_req = 1'b1;
    got = 0;
    repeat (10) begin @(negedge clk); if (b.init_ack) got = 1; end
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_mid.noack", 64'(got), 0);
    chk_rst("rst_mid");
    b.init_req = 1'b0;
    m_clear();
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk_occ("rst_mid");
    op_search(48'h77);

    // Randomised mix over a key pool larger than the table
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(99);
      k = KW'($urandom_range(95));
      if      (r < 45) op_write(k, DW'($urandom));
      else if (r < 70) op_search(k);
      else if (r < 80) op_age();
      else if (r < 98) op_ref($urandom_range(DEPTH - 1));
      else             op_init();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
